// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master among REQ_NUM requesters.
// Optional XFER abort timer is enabled by defining APB_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no grant; pick next eligible requester after `last`
// XFER    | command latched into M_*; waiting for PENABLE & PREADY
module apb_req_arbiter #(
  parameter int REQ_NUM        = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 4,
  parameter int STRB_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                               PCLK,
  input  logic                               PRESETn,
  input  logic [REQ_NUM-1:0]                 REQ_VALID,
  input  logic [REQ_NUM-1:0]                 REQ_WRITE,
  input  logic [REQ_NUM*ADDRESS_WIDTH-1:0]   REQ_ADDR,
  input  logic [REQ_NUM*DATA_WIDTH-1:0]      REQ_WDATA,
  input  logic [REQ_NUM*STRB_WIDTH-1:0]      REQ_STRB,
  output logic [REQ_NUM-1:0]                 REQ_GRANT,
  output logic [REQ_NUM-1:0]                 REQ_DONE,
  output logic [DATA_WIDTH-1:0]              RSP_RDATA,
  output logic                               RSP_SLVERR,
  output logic                               M_TRANSFER,
  output logic                               M_WRITE,
  output logic [ADDRESS_WIDTH-1:0]           M_ADDR,
  output logic [DATA_WIDTH-1:0]              M_WDATA,
  output logic [STRB_WIDTH-1:0]              M_STRB,
  input  logic                               PENABLE,
  input  logic                               PREADY,
  input  logic                               PSLVERR,
  input  logic [DATA_WIDTH-1:0]              PRDATA
);

  localparam int AW    = ADDRESS_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int SW    = STRB_WIDTH;
  localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  if (REQ_NUM < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_req_arbiter: REQ_NUM must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [0:0]         state;
  logic [PTR_W-1:0]   last;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand;
  logic               win_found;
  logic [REQ_NUM-1:0] eligible;
  logic [REQ_NUM-1:0] grant_next;
  logic               sel_write;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;
  logic [SW-1:0]      sel_strb;
  logic               complete;
  logic               timeout_hit;

  // A requester in its done cycle is masked so it cannot be re-granted at once.
  assign eligible   = REQ_VALID & ~REQ_DONE;
  assign complete   = PENABLE & PREADY;
  assign M_TRANSFER = (state == ST_XFER) & ~complete;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= REQ_NUM; k++) begin
      cand = PTR_W'((int'(last) + k) % REQ_NUM);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_next = '0;
    sel_write  = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_strb   = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (win_idx == PTR_W'(i)) begin
        grant_next[i] = 1'b1;
        sel_write     = REQ_WRITE[i];
        sel_addr      = REQ_ADDR[i*AW +: AW];
        sel_wdata     = REQ_WDATA[i*DW +: DW];
        sel_strb      = REQ_STRB[i*SW +: SW];
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      to_cnt <= '0;
    end else if (state == ST_IDLE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == ST_XFER) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= ST_IDLE;
      last       <= PTR_W'(REQ_NUM - 1);
      REQ_GRANT  <= '0;
      REQ_DONE   <= '0;
      RSP_RDATA  <= '0;
      RSP_SLVERR <= 1'b0;
      M_WRITE    <= 1'b0;
      M_ADDR     <= '0;
      M_WDATA    <= '0;
      M_STRB     <= '0;
    end else begin
      REQ_DONE <= '0;
      if (state == ST_IDLE) begin
        if (win_found) begin
          state     <= ST_XFER;
          last      <= win_idx;
          REQ_GRANT <= grant_next;
          M_WRITE   <= sel_write;
          M_ADDR    <= sel_addr;
          M_WDATA   <= sel_write ? sel_wdata : '0;
          M_STRB    <= sel_write ? sel_strb : '0;
        end
      end else begin
        // Completion takes precedence over a coincident timeout.
        if (complete) begin
          state      <= ST_IDLE;
          REQ_GRANT  <= '0;
          REQ_DONE   <= REQ_GRANT;
          RSP_SLVERR <= PSLVERR;
          RSP_RDATA  <= M_WRITE ? '0 : PRDATA;
        end else if (timeout_hit) begin
          state      <= ST_IDLE;
          REQ_GRANT  <= '0;
          REQ_DONE   <= REQ_GRANT;
          RSP_SLVERR <= 1'b1;
          RSP_RDATA  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: the bench plays the APB master by
// driving PENABLE/PREADY/PSLVERR/PRDATA on the cycles the master would.
module tb_apb_req_arbiter;

  localparam int RN = 2;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int SW = 4;

  logic              PCLK;
  logic              PRESETn;
  logic [RN-1:0]     REQ_VALID;
  logic [RN-1:0]     REQ_WRITE;
  logic [RN*AW-1:0]  REQ_ADDR;
  logic [RN*DW-1:0]  REQ_WDATA;
  logic [RN*SW-1:0]  REQ_STRB;
  logic [RN-1:0]     REQ_GRANT;
  logic [RN-1:0]     REQ_DONE;
  logic [DW-1:0]     RSP_RDATA;
  logic              RSP_SLVERR;
  logic              M_TRANSFER;
  logic              M_WRITE;
  logic [AW-1:0]     M_ADDR;
  logic [DW-1:0]     M_WDATA;
  logic [SW-1:0]     M_STRB;
  logic              PENABLE;
  logic              PREADY;
  logic              PSLVERR;
  logic [DW-1:0]     PRDATA;

  int errors = 0;
  int checks = 0;

  apb_req_arbiter #(
    .REQ_NUM(RN), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_STRB(REQ_STRB),
    .REQ_GRANT(REQ_GRANT), .REQ_DONE(REQ_DONE),
    .RSP_RDATA(RSP_RDATA), .RSP_SLVERR(RSP_SLVERR),
    .M_TRANSFER(M_TRANSFER), .M_WRITE(M_WRITE), .M_ADDR(M_ADDR),
    .M_WDATA(M_WDATA), .M_STRB(M_STRB),
    .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  // Entered just after the grant edge; returns just after the completion edge.
  task automatic serve(input logic [1:0] g, input logic w, input logic [3:0] a,
                       input logic [31:0] wd, input logic [3:0] st, input int waits,
                       input logic [31:0] prd, input logic err,
                       input logic [31:0] exp_rd, input logic exp_err);
    checks++;
    if (REQ_GRANT !== g) begin
      errors++; $display("FAIL grant: got %b expected %b", REQ_GRANT, g);
    end
    checks++;
    if ({M_WRITE, M_ADDR, M_WDATA, M_STRB} !== {w, a, wd, st}) begin
      errors++;
      $display("FAIL m_cmd: got w=%b a=%h d=%h s=%h expected w=%b a=%h d=%h s=%h",
               M_WRITE, M_ADDR, M_WDATA, M_STRB, w, a, wd, st);
    end
    checks++;
    if (M_TRANSFER !== 1'b1) begin
      errors++; $display("FAIL transfer_grant: got %b expected 1", M_TRANSFER);
    end
    tick;
    tick;
    PENABLE = 1'b1;
    for (int i = 0; i < waits; i++) begin
      PREADY = 1'b0;
      #1;
      checks++;
      if (M_TRANSFER !== 1'b1 || {M_WRITE, M_ADDR, M_WDATA, M_STRB} !== {w, a, wd, st}) begin
        errors++;
        $display("FAIL wait_state: got tr=%b a=%h d=%h expected tr=1 a=%h d=%h",
                 M_TRANSFER, M_ADDR, M_WDATA, a, wd);
      end
      tick;
    end
    PREADY  = 1'b1;
    PRDATA  = prd;
    PSLVERR = err;
    #1;
    checks++;
    if (M_TRANSFER !== 1'b0) begin
      errors++; $display("FAIL transfer_drop: got %b expected 0", M_TRANSFER);
    end
    tick;
    PENABLE = 1'b0;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    #1;
    checks++;
    if (REQ_DONE !== g || REQ_GRANT !== 2'b00 || M_TRANSFER !== 1'b0) begin
      errors++;
      $display("FAIL done: got done=%b gnt=%b tr=%b expected done=%b gnt=00 tr=0",
               REQ_DONE, REQ_GRANT, M_TRANSFER, g);
    end
    checks++;
    if (RSP_RDATA !== exp_rd || RSP_SLVERR !== exp_err) begin
      errors++;
      $display("FAIL rsp: got rdata=%h err=%b expected rdata=%h err=%b",
               RSP_RDATA, RSP_SLVERR, exp_rd, exp_err);
    end
  endtask

  task automatic test_reset;
    PRESETn = 1'b0;
    #3;
    checks++;
    if ({REQ_GRANT, REQ_DONE, RSP_RDATA, RSP_SLVERR, M_TRANSFER, M_WRITE, M_ADDR, M_WDATA, M_STRB} !== '0) begin
      errors++;
      $display("FAIL reset_values: got gnt=%b done=%b rd=%h tr=%b a=%h expected all zero",
               REQ_GRANT, REQ_DONE, RSP_RDATA, M_TRANSFER, M_ADDR);
    end
    tick;
    PRESETn = 1'b1;
    tick;
    tick;
    checks++;
    if (REQ_GRANT !== 2'b00 || M_TRANSFER !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: got gnt=%b tr=%b expected 00/0", REQ_GRANT, M_TRANSFER);
    end
  endtask

  task automatic test_back_to_back;
    PRESETn   = 1'b0;
    REQ_VALID = 2'b11;
    REQ_WRITE = 2'b00;
    REQ_ADDR  = {4'h2, 4'h1};
    REQ_WDATA = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
    REQ_STRB  = 8'hFF;
    tick;
    PRESETn = 1'b1;
    tick;
    serve(2'b01, 1'b0, 4'h1, 32'h0, 4'h0, 0, 32'h1111_0001, 1'b0, 32'h1111_0001, 1'b0);
    tick;
    serve(2'b10, 1'b0, 4'h2, 32'h0, 4'h0, 0, 32'h2222_0002, 1'b0, 32'h2222_0002, 1'b0);
    tick;
    serve(2'b01, 1'b0, 4'h1, 32'h0, 4'h0, 0, 32'h1111_0003, 1'b0, 32'h1111_0003, 1'b0);
    tick;
    serve(2'b10, 1'b0, 4'h2, 32'h0, 4'h0, 1, 32'h2222_0004, 1'b0, 32'h2222_0004, 1'b0);
    REQ_VALID = 2'b00;
    tick;
    checks++;
    if (REQ_GRANT !== 2'b00 || REQ_DONE !== 2'b00) begin
      errors++; $display("FAIL b2b_idle: got gnt=%b done=%b expected 00/00", REQ_GRANT, REQ_DONE);
    end
  endtask

  task automatic test_single_read;
    REQ_VALID = 2'b01;
    REQ_WRITE = 2'b00;
    REQ_ADDR  = {4'h0, 4'h3};
    tick;
    serve(2'b01, 1'b0, 4'h3, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0);
    REQ_VALID = 2'b00;
    tick;
    checks++;
    if (REQ_DONE !== 2'b00 || RSP_RDATA !== 32'hDEAD_BEEF || REQ_GRANT !== 2'b00) begin
      errors++;
      $display("FAIL read_hold: got done=%b rd=%h gnt=%b expected 00/deadbeef/00",
               REQ_DONE, RSP_RDATA, REQ_GRANT);
    end
  endtask

  task automatic test_write_wait;
    REQ_VALID = 2'b10;
    REQ_WRITE = 2'b10;
    REQ_ADDR  = {4'h9, 4'h0};
    REQ_WDATA = {32'h1234_5678, 32'h0};
    REQ_STRB  = {4'hF, 4'h0};
    tick;
    // Requester inputs change after grant and must not leak into M_*.
    REQ_VALID = 2'b00;
    REQ_WRITE = 2'b00;
    REQ_ADDR  = {4'h5, 4'h0};
    REQ_WDATA = {32'h0BAD_0BAD, 32'h0};
    REQ_STRB  = {4'h1, 4'h0};
    serve(2'b10, 1'b1, 4'h9, 32'h1234_5678, 4'hF, 3, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
    tick;
  endtask

  task automatic test_slverr;
    REQ_VALID = 2'b01;
    REQ_WRITE = 2'b01;
    REQ_ADDR  = {4'h0, 4'h4};
    REQ_WDATA = {32'h0, 32'h0000_0055};
    REQ_STRB  = {4'h0, 4'h3};
    tick;
    serve(2'b01, 1'b1, 4'h4, 32'h0000_0055, 4'h3, 1, 32'h0000_0077, 1'b1, 32'h0, 1'b1);
    REQ_VALID = 2'b00;
    tick;
    checks++;
    if (RSP_SLVERR !== 1'b1) begin
      errors++; $display("FAIL slverr_hold: got %b expected 1", RSP_SLVERR);
    end
    REQ_VALID = 2'b01;
    REQ_WRITE = 2'b00;
    REQ_ADDR  = {4'h0, 4'h5};
    tick;
    serve(2'b01, 1'b0, 4'h5, 32'h0, 4'h0, 0, 32'h0000_00A5, 1'b0, 32'h0000_00A5, 1'b0);
    REQ_VALID = 2'b00;
    tick;
  endtask

  task automatic test_reset_mid;
    REQ_VALID = 2'b01;
    REQ_WRITE = 2'b00;
    REQ_ADDR  = {4'h7, 4'h6};
    tick;
    tick;
    tick;
    PENABLE = 1'b1;
    PREADY  = 1'b0;
    tick;
    PRESETn = 1'b0;
    #1;
    checks++;
    if (REQ_GRANT !== 2'b00 || M_TRANSFER !== 1'b0 || REQ_DONE !== 2'b00 || M_ADDR !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid: got gnt=%b tr=%b done=%b a=%h expected 00/0/00/0",
               REQ_GRANT, M_TRANSFER, REQ_DONE, M_ADDR);
    end
    PENABLE = 1'b0;
    tick;
    checks++;
    if (REQ_DONE !== 2'b00) begin
      errors++; $display("FAIL reset_no_done: got %b expected 00", REQ_DONE);
    end
    PRESETn   = 1'b1;
    REQ_VALID = 2'b11;
    tick;
    serve(2'b01, 1'b0, 4'h6, 32'h0, 4'h0, 0, 32'h6666_6666, 1'b0, 32'h6666_6666, 1'b0);
    REQ_VALID = 2'b00;
    tick;
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    n = 0;
    REQ_VALID = 2'b01;
    REQ_WRITE = 2'b00;
    REQ_ADDR  = {4'h0, 4'h2};
    tick;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      tick;
      if (i == 2) PENABLE = 1'b1;
      if (REQ_DONE !== 2'b00) n = i;
    end
    PENABLE   = 1'b0;
    REQ_VALID = 2'b00;
    checks++;
    if (n != 16) begin
      errors++; $display("FAIL timeout_latency: got %0d expected 16", n);
    end
    checks++;
    if (RSP_SLVERR !== 1'b1 || RSP_RDATA !== 32'h0 || M_TRANSFER !== 1'b0) begin
      errors++;
      $display("FAIL timeout_rsp: got err=%b rd=%h tr=%b expected 1/0/0",
               RSP_SLVERR, RSP_RDATA, M_TRANSFER);
    end
    tick;
  endtask
`endif

  initial begin
    PRESETn   = 1'b0;
    REQ_VALID = '0;
    REQ_WRITE = '0;
    REQ_ADDR  = '0;
    REQ_WDATA = '0;
    REQ_STRB  = '0;
    PENABLE   = 1'b0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = '0;
    test_reset;
    test_back_to_back;
    test_single_read;
    test_write_wait;
    test_slverr;
    test_reset_mid;
`ifdef APB_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
